// File: rtl/pool5_pkg.sv
// Shared definitions for the pool5 result-memory controller: FSM encoding,
// output FIFO geometry and the occupancy helper used for read throttling.
package pool5_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int unsigned FIFO_DEPTH = 32'd4;
    localparam int unsigned FIFO_PTR_W = 32'd2;
    localparam int unsigned FIFO_CNT_W = 32'd3;

    // Words already buffered plus words still travelling through the RAM pipe.
    function automatic logic [FIFO_CNT_W-1:0] occupancy(
        input logic [FIFO_CNT_W-1:0] fifo_cnt,
        input logic [1:0]            inflight
    );
        return fifo_cnt + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/pool5_rd_fifo.sv
// Four-entry output FIFO holding {last, data}; head is read combinationally
// so it stays stable while the consumer stalls.
module pool5_rd_fifo
    import pool5_pkg::*;
#(
    parameter int W = 65
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [W-1:0]          din_i,
    input  logic                  pop_i,
    output logic [W-1:0]          dout_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    logic [W-1:0]            mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]   wr_ptr_q;
    logic [FIFO_PTR_W-1:0]   rd_ptr_q;
    logic [FIFO_CNT_W-1:0]   count_q;
    logic                    push_s;
    logic                    pop_s;

    assign push_s  = push_i && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
    assign pop_s   = pop_i && (count_q != 3'd0);
    assign empty_o = (count_q == 3'd0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pool5_rm_ctrl.sv
// Buffers one pool5 frame into an external 2-cycle-latency RAM, then replays
// it NUM_PASS times to a ready/valid consumer through a small output FIFO.
module pool5_rm_ctrl
    import pool5_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 64,
    parameter int FRAME_LEN = 2080,
    parameter int NUM_PASS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              frame_done,
    output logic              busy
);

    localparam int PASS_W = 9;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [PASS_W-1:0] PASS_END  = PASS_W'(NUM_PASS);

    state_e                  state_q;
    logic [ADDR_W-1:0]       wr_cnt_q;
    logic [ADDR_W-1:0]       rd_addr_q;
    logic [ADDR_W-1:0]       addrb_q;
    logic [PASS_W-1:0]       pass_cnt_q;
    logic                    frame_done_q;
    logic                    rv1_q, rv2_q, rl1_q, rl2_q;
    logic                    wr_beat_s, issue_s, rd_at_end_s, fifo_empty_s;
    logic [1:0]              inflight_s;
    logic [FIFO_CNT_W-1:0]   fifo_cnt_s;
    logic [PASS_W-1:0]       pass_next_s;
    logic [DATA_W:0]         fifo_dout_s;

    assign wr_ready    = (state_q == ST_FILL);
    assign wr_beat_s   = wr_valid && wr_ready;
    assign ram_wea     = wr_beat_s;
    assign ram_addra   = wr_cnt_q;
    assign ram_dina    = wr_data;

    assign inflight_s  = {1'b0, rv1_q} + {1'b0, rv2_q};
    assign issue_s     = (state_q == ST_DRAIN) &&
                         (occupancy(fifo_cnt_s, inflight_s) < FIFO_CNT_W'(FIFO_DEPTH));
    assign rd_at_end_s = (rd_addr_q == LAST_ADDR);
    assign pass_next_s = pass_cnt_q + 9'd1;
    // The RAM samples the address in the issue cycle; otherwise it sees the last one.
    assign ram_addrb   = issue_s ? rd_addr_q : addrb_q;

    assign busy        = (state_q != ST_FILL);
    assign frame_done  = frame_done_q;
    assign rd_valid    = !fifo_empty_s;
    assign rd_data     = fifo_dout_s[DATA_W-1:0];
    assign rd_last     = fifo_dout_s[DATA_W] && !fifo_empty_s;

    // Control FSM with write/read address and pass counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            wr_cnt_q     <= '0;
            rd_addr_q    <= '0;
            addrb_q      <= '0;
            pass_cnt_q   <= 9'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (wr_beat_s) begin
                        if (wr_cnt_q == LAST_ADDR) begin
                            state_q    <= ST_DRAIN;
                            wr_cnt_q   <= '0;
                            rd_addr_q  <= '0;
                            pass_cnt_q <= 9'd0;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + ADDR_W'(1'b1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (issue_s) begin
                        addrb_q <= rd_addr_q;
                        if (rd_at_end_s) begin
                            rd_addr_q  <= '0;
                            pass_cnt_q <= pass_next_s;
                            if (pass_next_s == PASS_END) begin
                                state_q <= ST_FLUSH;
                            end
                        end else begin
                            rd_addr_q <= rd_addr_q + ADDR_W'(1'b1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if ((inflight_s == 2'd0) && fifo_empty_s) begin
                        frame_done_q <= 1'b1;
                        state_q      <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    // Tracks issued reads through the RAM latency so only their data is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1_q <= 1'b0;
            rv2_q <= 1'b0;
            rl1_q <= 1'b0;
            rl2_q <= 1'b0;
        end else begin
            rv1_q <= issue_s;
            rl1_q <= issue_s && rd_at_end_s;
            rv2_q <= rv1_q;
            rl2_q <= rl1_q;
        end
    end

    pool5_rd_fifo #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rv2_q),
        .din_i   ({rl2_q, ram_doutb}),
        .pop_i   (rd_valid && rd_ready),
        .dout_o  (fifo_dout_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_cnt_s)
    );

endmodule

// File: tb/tb_pool5_rm_ctrl.sv
// Directed bench for pool5_rm_ctrl with FRAME_LEN=8, NUM_PASS=2 and a
// behavioural 2-cycle-latency RAM.
module tb_pool5_rm_ctrl;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = 16'd0;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_doutb = 16'd0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          frame_done;
    logic          busy;

    int checks = 0;
    int failures = 0;

    pool5_rm_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(8), .NUM_PASS(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: address in cycle k, data visible in cycle k+2
    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] ram_p1;
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra[3:0]] <= ram_dina;
        ram_p1    <= mem[ram_addrb[3:0]];
        ram_doutb <= ram_p1;
    end

    task test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (ram_wea !== 1'b0) begin failures++; $display("FAIL reset_wea got=%0b exp=0", ram_wea); end
        checks++; if (ram_addrb !== 12'd0) begin failures++; $display("FAIL reset_addrb got=%0h exp=0", ram_addrb); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin failures++; $display("FAIL reset_rd_last got=%0b exp=0", rd_last); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
        @(posedge clk); #1;
    endtask

    // Writes 8 words base..base+7; gap_at<8 inserts one idle cycle before that beat.
    task write_frame(input logic [DW-1:0] base, input int gap_at);
        int idx;
        idx = 0;
        for (int k = 0; k < ((gap_at < 8) ? 9 : 8); k++) begin
            if (k == gap_at) begin
                wr_valid = 1'b0;
                #1;
                checks++; if (ram_wea !== 1'b0) begin failures++; $display("FAIL wr_gap_wea got=%0b exp=0", ram_wea); end
            end else begin
                wr_valid = 1'b1;
                wr_data  = base + 16'(idx);
                #1;
                checks++; if (ram_wea !== 1'b1) begin failures++; $display("FAIL wr_wea beat=%0d got=%0b exp=1", idx, ram_wea); end
                checks++; if (ram_addra !== 12'(idx)) begin failures++; $display("FAIL wr_addra beat=%0d got=%0h exp=%0h", idx, ram_addra, idx); end
                checks++; if (ram_dina !== base + 16'(idx)) begin failures++; $display("FAIL wr_dina beat=%0d got=%0h exp=%0h", idx, ram_dina, base + 16'(idx)); end
                checks++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wr_fill_state beat=%0d wr_ready=%0b busy=%0b exp 1/0", idx, wr_ready, busy); end
                idx++;
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    // mode 0: ready=1; mode 1: ready 1,0,0,1; mode 2: ready=0 for 20 cycles then 1.
    task drain_frame(input logic [DW-1:0] base, input int mode, input int stop_after, input bit hold_wr);
        int c, n, fd;
        bit done, prev_stall;
        logic [DW-1:0] prev_data, exp_d;
        logic [AW-1:0] exp_a;
        c = 0; n = 0; fd = 0; done = 1'b0; prev_stall = 1'b0; prev_data = 16'd0;
        while (!done && c < 400) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
                2:       rd_ready = (c >= 20);
                default: rd_ready = 1'b1;
            endcase
            wr_valid = hold_wr ? busy : 1'b0;
            wr_data  = 16'hDEAD;
            #1;
            if (c == 0) begin
                checks++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin failures++; $display("FAIL drain_entry busy=%0b wr_ready=%0b exp 1/0", busy, wr_ready); end
            end
            if (hold_wr && busy) begin
                checks++; if (ram_wea !== 1'b0) begin failures++; $display("FAIL drain_wea cyc=%0d got=%0b exp=0", c, ram_wea); end
            end
            if (mode == 0 && c <= 20) begin
                checks++; if (rd_valid !== (c >= 3 && c <= 18)) begin failures++; $display("FAIL drain_valid_timing cyc=%0d got=%0b exp=%0b", c, rd_valid, (c >= 3 && c <= 18)); end
                checks++; if (frame_done !== (c == 20)) begin failures++; $display("FAIL frame_done_timing cyc=%0d got=%0b exp=%0b", c, frame_done, (c == 20)); end
            end
            if (mode == 2 && c < 20) begin
                exp_a = (c < 4) ? 12'(c) : 12'd3;
                checks++; if (ram_addrb !== exp_a) begin failures++; $display("FAIL stall_addrb cyc=%0d got=%0h exp=%0h", c, ram_addrb, exp_a); end
            end
            if (prev_stall) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== prev_data) begin failures++; $display("FAIL stall_hold cyc=%0d valid=%0b data=%0h exp valid=1 data=%0h", c, rd_valid, rd_data, prev_data); end
            end
            if (rd_valid && rd_ready) begin
                exp_d = base + 16'(n % 8);
                checks++; if (rd_data !== exp_d) begin failures++; $display("FAIL rd_data word=%0d got=%0h exp=%0h", n, rd_data, exp_d); end
                checks++; if (rd_last !== ((n % 8) == 7)) begin failures++; $display("FAIL rd_last word=%0d got=%0b exp=%0b", n, rd_last, ((n % 8) == 7)); end
                n++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (frame_done) begin
                fd++;
                done = 1'b1;
            end
            if (stop_after > 0 && n == stop_after) done = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        wr_valid = 1'b0;
        if (stop_after == 0) begin
            checks++; if (!done) begin failures++; $display("FAIL drain_timeout got=no_frame_done exp=frame_done"); end
            checks++; if (n != 16 || fd != 1) begin failures++; $display("FAIL drain_count words=%0d pulses=%0d exp 16/1", n, fd); end
            #1;
            checks++; if (frame_done !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_frame done=%0b wr_ready=%0b busy=%0b exp 0/1/0", frame_done, wr_ready, busy); end
            @(posedge clk); #1;
        end
    endtask

    task test_fill_drain;
        write_frame(16'h0010, 99);
        drain_frame(16'h0010, 0, 0, 1'b0);
    endtask

    task test_stall_toggle;
        write_frame(16'h0010, 3);
        drain_frame(16'h0010, 1, 0, 1'b0);
    endtask

    task test_backpressure;
        write_frame(16'h0030, 99);
        drain_frame(16'h0030, 2, 0, 1'b0);
    endtask

    task test_wr_hold_in_drain;
        write_frame(16'h0050, 99);
        drain_frame(16'h0050, 0, 0, 1'b1);
    endtask

    task test_reset_mid_drain;
        write_frame(16'h0020, 99);
        drain_frame(16'h0020, 0, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin failures++; $display("FAIL midrst_rd valid=%0b last=%0b exp 0/0", rd_valid, rd_last); end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL midrst_state busy=%0b done=%0b exp 0/0", busy, frame_done); end
        checks++; if (ram_addrb !== 12'd0 || ram_wea !== 1'b0) begin failures++; $display("FAIL midrst_ram addrb=%0h wea=%0b exp 0/0", ram_addrb, ram_wea); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL midrst_wr_ready got=%0b exp=1", wr_ready); end
        write_frame(16'h0040, 99);
        drain_frame(16'h0040, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_stall_toggle;
        test_backpressure;
        test_wr_hold_in_drain;
        test_reset_mid_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool5_rm_ctrl.md
POOL5_RM_CTRL -- requirements
Module: pool5_rm_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning RAM address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning RAM word width.
REQ-003 SHALL have parameter FRAME_LEN, default 2080, meaning words per pool5 frame (2 to 2**ADDR_W).
REQ-004 SHALL have parameter NUM_PASS, default 1, meaning full read passes per frame (1 to 256).
REQ-005 SHALL have port clk  input  1  single clock for all logic; RAM port A and port B share it.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports wr_valid input 1, wr_ready output 1, wr_data input DATA_W: pool5 result stream.
REQ-008 SHALL have ports ram_wea output 1, ram_addra output ADDR_W, ram_dina output DATA_W: RAM write port.
REQ-009 SHALL have ports ram_addrb output ADDR_W, ram_doutb input DATA_W: RAM read port, fixed 2-cycle read latency, always enabled.
REQ-010 SHALL have ports rd_valid output 1, rd_ready input 1, rd_data output DATA_W, rd_last output 1: downstream stream.
REQ-011 SHALL have ports frame_done output 1 (one-cycle pulse) and busy output 1.

Function
REQ-012 FSM states SHALL be FILL, DRAIN, FLUSH; reset state FILL.
REQ-013 In FILL, wr_ready SHALL be 1; each wr_valid&wr_ready beat drives ram_wea=1, ram_dina=wr_data, ram_addra=wr_cnt in the same cycle (combinational pass-through), then wr_cnt increments.
REQ-014 On the beat with wr_cnt==FRAME_LEN-1, FSM SHALL move to DRAIN next cycle and clear wr_cnt and pass_cnt.
REQ-015 wr_ready SHALL be 0 in DRAIN and FLUSH; ram_wea SHALL be 0 whenever wr_ready is 0.
REQ-016 In DRAIN, a read SHALL be issued (ram_addrb=rd_addr, rd_addr increments) only when out_fifo_count + inflight < 4; inflight = number of issued reads whose data has not yet returned (0..2).
REQ-017 Read data SHALL be captured into a 4-entry output FIFO exactly 2 cycles after issue, tagged with last=1 when issued address was FRAME_LEN-1.
REQ-018 rd_valid SHALL equal FIFO non-empty; rd_data/rd_last from FIFO head; pop on rd_valid&rd_ready; rd_data SHALL hold stable while rd_valid&!rd_ready.
REQ-019 After issuing address FRAME_LEN-1, rd_addr SHALL wrap to 0 and pass_cnt increment; when pass_cnt reaches NUM_PASS, no further reads issue and FSM enters FLUSH.
REQ-020 FLUSH SHALL wait until inflight==0 and FIFO empty, then pulse frame_done for one cycle and return to FILL.
REQ-021 busy SHALL be 1 in DRAIN and FLUSH, 0 in FILL.
REQ-022 With rd_ready held 1, sustained throughput SHALL be one word per cycle; first rd_valid SHALL appear 3 cycles after entering DRAIN.
REQ-023 FIFO push and pop in the same cycle SHALL keep count unchanged; FIFO SHALL never overflow (guaranteed by REQ-016).
REQ-024 ram_addrb SHALL hold its last value when no read is issued; stale returning data SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously clear state to FILL, wr_cnt, rd_addr, pass_cnt, inflight pipeline, FIFO pointers/count to 0.
REQ-026 During and after reset: wr_ready=1 (after release), ram_wea=0, ram_addrb=0, rd_valid=0, rd_last=0, frame_done=0, busy=0.
REQ-027 Reset mid-DRAIN SHALL discard in-flight and buffered data; RAM contents are not cleared.

Structure
REQ-028 FSM state encoding and FIFO depth constant (4) SHALL live in shared package pool5_pkg.
REQ-029 Output FIFO SHALL be a separate sub-module pool5_rd_fifo (4-entry, DATA_W+1 bits).
REQ-030 The RAM SHALL be instantiated outside this block; this block contains no memory macro.

Verification (FRAME_LEN=8, NUM_PASS=2, behavioural 2-cycle RAM model)
REQ-031 Write 8 words 0x10..0x17 with wr_valid=1 -> ram_addra 0..7, busy rises cycle after 8th beat, wr_ready=0.
REQ-032 rd_ready=1 constant -> 16 words 0x10..0x17,0x10..0x17 on consecutive cycles, rd_last on 8th and 16th, frame_done pulse once, then wr_ready=1.
REQ-033 rd_ready toggling 1,0,0,1 pattern -> no lost/duplicated words, rd_data stable during stall, FIFO count never exceeds 4.
REQ-034 rd_ready=0 for 20 cycles after DRAIN entry -> exactly 4 reads issued, then resumes; sequence intact.
REQ-035 rst_n pulsed low during DRAIN (after 5 outputs) -> rd_valid=0 immediately, state FILL, next frame written from address 0.
REQ-036 wr_valid held 1 during DRAIN -> no ram_wea assertion, wr_cnt unchanged.
